// File: rtl/mem_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_if
// Purpose : bundles the CPU port, the LCD refresh DMA port and the external
//           memory bus pins that mem_bus_arbiter owns.
// Modports:
//   slave  - arbiter side: takes requests, drives acks/read data and the bus.
//   master - environment side: the requesters plus the memory device.
// Signals:
//   cpu_req_in/cpu_we_in/cpu_addr_in/cpu_data_in  CPU request (held until ack)
//   cpu_data_o/cpu_ack_o                           CPU read data, completion pulse
//   dma_req_in/dma_addr_in                         DMA read request (held until ack)
//   dma_data_o/dma_ack_o                           DMA read data, completion pulse
//   addr_o/oe_o/we_o                               external address, strobes (low active)
//   mem_data_o/mem_data_oe_o/mem_data_in           data_io split into out/enable/in
// -----------------------------------------------------------------------------
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 19
);
    logic              cpu_req_in;
    logic              cpu_we_in;
    logic [ADDR_W-1:0] cpu_addr_in;
    logic [15:0]       cpu_data_in;
    logic [15:0]       cpu_data_o;
    logic              cpu_ack_o;

    logic              dma_req_in;
    logic [ADDR_W-1:0] dma_addr_in;
    logic [15:0]       dma_data_o;
    logic              dma_ack_o;

    logic [ADDR_W-1:0] addr_o;
    logic              oe_o;
    logic              we_o;
    logic [15:0]       mem_data_o;
    logic              mem_data_oe_o;
    logic [15:0]       mem_data_in;

    modport slave (
        input  cpu_req_in, cpu_we_in, cpu_addr_in, cpu_data_in,
        output cpu_data_o, cpu_ack_o,
        input  dma_req_in, dma_addr_in,
        output dma_data_o, dma_ack_o,
        output addr_o, oe_o, we_o, mem_data_o, mem_data_oe_o,
        input  mem_data_in
    );

    modport master (
        output cpu_req_in, cpu_we_in, cpu_addr_in, cpu_data_in,
        input  cpu_data_o, cpu_ack_o,
        output dma_req_in, dma_addr_in,
        input  dma_data_o, dma_ack_o,
        input  addr_o, oe_o, we_o, mem_data_o, mem_data_oe_o,
        output mem_data_in
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Purpose : owns the external 16-bit memory bus and shares it between the CPU
//           port and the LCD refresh DMA port (DMA is read-only). Each access
//           runs IDLE -> SETUP -> ACCESS (WAIT_STATES+1 cycles) -> HOLD -> IDLE,
//           one access at a time. The top level builds the data_io tristate
//           from mem_data_o / mem_data_oe_o.
// Parameters:
//   ADDR_W       external word address width
//   WAIT_STATES  extra ACCESS cycles beyond the first (0..15)
// Ports:
//   clk_in    system clock
//   reset_in  asynchronous reset, active high (aborts any access, no ack)
//   bus       mem_bus_arbiter_if.slave (CPU port, DMA port, memory pins)
// Build option:
//   MEMARB_DMA_PRIO_EN  when defined, DMA wins every tie (fixed priority);
//                       otherwise ties alternate round robin via last grant.
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int ADDR_W      = 19,
    parameter int WAIT_STATES = 2
) (
    input  logic                clk_in,
    input  logic                reset_in,
    mem_bus_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

    state_t            state, state_nx;
    logic [3:0]        wait_cnt, wait_cnt_nx;

    // Transaction context latched at grant; the request inputs are ignored
    // until the arbiter is back in IDLE.
    logic              sel_dma;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q;
    logic [15:0]       cpu_rdata;
    logic [15:0]       dma_rdata;

    logic              grant;
    logic              grant_dma;
    logic              last_access;

    // ---------------------------------------------------------------------
    // Arbitration
    // ---------------------------------------------------------------------
`ifdef MEMARB_DMA_PRIO_EN
    // DMA keeps the LCD fed; the CPU only gets the bus when DMA is quiet.
    assign grant_dma = bus.dma_req_in;
`else
    logic last_dma;  // 1 = the previous grant went to DMA

    // On a tie, hand the bus to whichever port did not win last time.
    assign grant_dma = bus.dma_req_in & (~bus.cpu_req_in | ~last_dma);

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in)
            last_dma <= 1'b0;
        else if (state == IDLE && grant)
            last_dma <= grant_dma;
    end
`endif

    assign grant       = bus.cpu_req_in | bus.dma_req_in;
    assign last_access = (state == ACCESS) && (wait_cnt == 4'd0);

    // ---------------------------------------------------------------------
    // FSM state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
        end
    end

    // ---------------------------------------------------------------------
    // FSM next state and bus strobes
    // ---------------------------------------------------------------------
    always_comb begin
        state_nx          = state;
        wait_cnt_nx       = wait_cnt;
        bus.oe_o          = 1'b1;
        bus.we_o          = 1'b1;
        bus.mem_data_oe_o = 1'b0;
        bus.cpu_ack_o     = 1'b0;
        bus.dma_ack_o     = 1'b0;

        case (state)
            IDLE: begin
                if (grant)
                    state_nx = SETUP;
            end
            SETUP: begin
                bus.mem_data_oe_o = we_q;
                wait_cnt_nx       = 4'(WAIT_STATES);
                state_nx          = ACCESS;
            end
            ACCESS: begin
                bus.mem_data_oe_o = we_q;
                bus.oe_o          = we_q;
                bus.we_o          = ~we_q;
                if (wait_cnt == 4'd0)
                    state_nx = HOLD;
                else
                    wait_cnt_nx = wait_cnt - 4'd1;
            end
            HOLD: begin
                // Strobes are already high; address and write data stay on
                // the bus one more cycle for hold time.
                bus.mem_data_oe_o = we_q;
                bus.cpu_ack_o     = ~sel_dma;
                bus.dma_ack_o     = sel_dma;
                state_nx          = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath: latch at grant, capture read data on the last ACCESS edge
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            sel_dma   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 16'h0000;
            cpu_rdata <= 16'h0000;
            dma_rdata <= 16'h0000;
        end else begin
            if (state == IDLE && grant) begin
                sel_dma <= grant_dma;
                we_q    <= ~grant_dma & bus.cpu_we_in;
                addr_q  <= grant_dma ? bus.dma_addr_in : bus.cpu_addr_in;
                if (!grant_dma && bus.cpu_we_in)
                    wdata_q <= bus.cpu_data_in;
            end
            if (last_access && !we_q) begin
                if (sel_dma)
                    dma_rdata <= bus.mem_data_in;
                else
                    cpu_rdata <= bus.mem_data_in;
            end
        end
    end

    // Address and data registers are not cleared in IDLE, so the bus keeps
    // its last value between accesses.
    assign bus.addr_o     = addr_q;
    assign bus.mem_data_o = wdata_q;
    assign bus.cpu_data_o = cpu_rdata;
    assign bus.dma_data_o = dma_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Bench for mem_bus_arbiter: a WAIT_STATES=2 instance for the directed and
// randomized transactions, plus a WAIT_STATES=0 instance for the short case.
// A 256-word memory device answers on the low address byte; a separate
// transaction-level reference memory and grant model give expected values.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;
    localparam int AW = 19;
    localparam int WS = 2;

    logic clk_in   = 1'b0;
    logic reset_in = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [15:0] tb_mem  [256];  // memory device on the bus
    logic [15:0] ref_mem [256];  // reference contents, updated per transaction
    bit          model_last_dma;

    mem_bus_arbiter_if #(.ADDR_W(AW)) b ();
    mem_bus_arbiter_if #(.ADDR_W(AW)) b0 ();

    mem_bus_arbiter #(.ADDR_W(AW), .WAIT_STATES(WS)) dut (
        .clk_in(clk_in), .reset_in(reset_in), .bus(b));
    mem_bus_arbiter #(.ADDR_W(AW), .WAIT_STATES(0)) dut0 (
        .clk_in(clk_in), .reset_in(reset_in), .bus(b0));

    always #5 clk_in = ~clk_in;

    assign b.mem_data_in  = tb_mem[b.addr_o[7:0]];
    assign b0.mem_data_in = tb_mem[b0.addr_o[7:0]];

    always @(posedge clk_in)
        if (!b.we_o && b.mem_data_oe_o)
            tb_mem[b.addr_o[7:0]] <= b.mem_data_o;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete transaction on the WAIT_STATES=2 instance, checked against
    // the grant rule and the reference memory.
    task automatic run_txn(input bit c, input bit d, input bit cwe,
                           input logic [AW-1:0] ca, input logic [15:0] cd,
                           input logic [AW-1:0] da, input bit drop_early);
        bit win_dma, exp_we, got;
        logic [AW-1:0] ea;
        logic [15:0] ed;
        int lat, nol, nwl, ndo;
        if (c && d) begin
`ifdef MEMARB_DMA_PRIO_EN
            win_dma = 1'b1;
`else
            win_dma = !model_last_dma;
`endif
        end else begin
            win_dma = d;
        end
        model_last_dma = win_dma;
        exp_we = !win_dma && cwe;
        ea = win_dma ? da : ca;
        if (exp_we) begin
            ref_mem[ea[7:0]] = cd;
            ed = cd;
        end else begin
            ed = ref_mem[ea[7:0]];
        end

        @(negedge clk_in);
        b.cpu_req_in = c; b.cpu_we_in = cwe; b.cpu_addr_in = ca; b.cpu_data_in = cd;
        b.dma_req_in = d; b.dma_addr_in = da;
        lat = 0; nol = 0; nwl = 0; ndo = 0; got = 0;
        while (!got && lat < 40) begin
            @(negedge clk_in);
            lat++;
            if (!b.oe_o) nol++;
            if (!b.we_o) nwl++;
            if (b.mem_data_oe_o) ndo++;
            if (b.cpu_ack_o || b.dma_ack_o) got = 1;
            if (drop_early && lat == 1) begin
                // Inputs after the grant must have no effect.
                b.cpu_req_in = 0; b.dma_req_in = 0;
                b.cpu_we_in = ~cwe; b.cpu_addr_in = ~ca; b.cpu_data_in = ~cd;
                b.dma_addr_in = ~da;
            end
        end
        check("ack_seen", 32'(got), 1);
        check("latency", lat, 3 + WS);
        check("cpu_ack", 32'(b.cpu_ack_o), 32'(!win_dma));
        check("dma_ack", 32'(b.dma_ack_o), 32'(win_dma));
        check("hold_addr", 32'(b.addr_o), 32'(ea));
        check("hold_oe_we", {b.oe_o, b.we_o}, 2'b11);
        if (exp_we) begin
            check("hold_wr_data", 32'(b.mem_data_o), 32'(cd));
            check("we_low_cycles", nwl, WS + 1);
            check("oe_low_on_write", nol, 0);
            check("data_oe_cycles", ndo, WS + 3);
        end else begin
            check("rd_data", 32'(win_dma ? b.dma_data_o : b.cpu_data_o), 32'(ed));
            check("oe_low_cycles", nol, WS + 1);
            check("we_low_on_read", nwl, 0);
            check("data_oe_on_read", ndo, 0);
        end
        b.cpu_req_in = 0; b.dma_req_in = 0;
        @(negedge clk_in);
        check("idle_acks", {b.cpu_ack_o, b.dma_ack_o}, 0);
        check("idle_strobes", {b.oe_o, b.we_o, b.mem_data_oe_o}, 3'b110);
    endtask

    initial begin
        logic [3:0] seq;
        int n, both, lat, nol, acks;
        bit got;
        logic [15:0] ed;

        b.cpu_req_in = 0; b.cpu_we_in = 0; b.cpu_addr_in = '0; b.cpu_data_in = '0;
        b.dma_req_in = 0; b.dma_addr_in = '0;
        b0.cpu_req_in = 0; b0.cpu_we_in = 0; b0.cpu_addr_in = '0; b0.cpu_data_in = '0;
        b0.dma_req_in = 0; b0.dma_addr_in = '0;
        for (int i = 0; i < 256; i++) begin
            tb_mem[i]  = 16'($urandom);
            ref_mem[i] = tb_mem[i];
        end
        model_last_dma = 0;

        #1 reset_in = 1'b1;
        repeat (3) @(negedge clk_in);
        check("rst_addr", 32'(b.addr_o), 0);
        check("rst_strobes", {b.oe_o, b.we_o, b.mem_data_oe_o}, 3'b110);
        check("rst_wdata", 32'(b.mem_data_o), 0);
        check("rst_acks", {b.cpu_ack_o, b.dma_ack_o}, 0);
        check("rst_rdata", {b.cpu_data_o, b.dma_data_o}, 0);
        reset_in = 1'b0;

        // CPU read of 0x00123 returning 0xBEEF
        tb_mem[8'h23] = 16'hBEEF; ref_mem[8'h23] = 16'hBEEF;
        run_txn(1, 0, 0, 19'h00123, 16'h0000, 19'h0, 0);
        check("t1_cpu_data", 32'(b.cpu_data_o), 32'h0000BEEF);

        // CPU write at the top of the address space, then read it back
        run_txn(1, 0, 1, 19'h7FFFF, 16'h1234, 19'h0, 0);
        run_txn(1, 0, 0, 19'h7FFFF, 16'h0000, 19'h0, 0);
        check("t2_readback", 32'(b.cpu_data_o), 32'h00001234);

        // Reset during the ACCESS phase of a write
        @(negedge clk_in);
        b.cpu_req_in = 1; b.cpu_we_in = 1; b.cpu_addr_in = 19'h00042;
        b.cpu_data_in = ref_mem[8'h42];
        for (int i = 0; i < 20 && b.we_o; i++) @(negedge clk_in);
        check("t4_we_low_before_rst", 32'(b.we_o), 0);
        #2 reset_in = 1'b1;
        #1;
        check("t4_we_released", 32'(b.we_o), 1);
        check("t4_data_oe_off", 32'(b.mem_data_oe_o), 0);
        check("t4_addr_cleared", 32'(b.addr_o), 0);
        b.cpu_req_in = 0;
        @(negedge clk_in);
        reset_in = 1'b0;
        acks = 0;
        repeat (10) begin
            @(negedge clk_in);
            if (b.cpu_ack_o || b.dma_ack_o) acks++;
        end
        check("t4_no_ack", acks, 0);
        model_last_dma = 0;
        run_txn(1, 0, 0, 19'h00042, 16'h0000, 19'h0, 0);

        // Both ports requesting continuously for four accesses
        @(negedge clk_in);
        b.cpu_req_in = 1; b.cpu_we_in = 0; b.cpu_addr_in = 19'h00010;
        b.dma_req_in = 1; b.dma_addr_in = 19'h00020;
        seq = 4'b0; n = 0; both = 0;
        for (int i = 0; i < 200 && n < 4; i++) begin
            @(negedge clk_in);
            if (b.cpu_ack_o && b.dma_ack_o) both++;
            if (b.dma_ack_o) begin seq[n] = 1'b1; n++; end
            else if (b.cpu_ack_o) begin seq[n] = 1'b0; n++; end
        end
        b.cpu_req_in = 0; b.dma_req_in = 0;
        check("t3_grant_count", n, 4);
        check("t3_both_acks", both, 0);
`ifdef MEMARB_DMA_PRIO_EN
        check("t3_grant_order", 32'(seq), 32'b1111);
`else
        check("t3_grant_order", 32'(seq), 32'b0101);
`endif
        check("t3_dma_data", 32'(b.dma_data_o), 32'(ref_mem[8'h20]));
        model_last_dma = 0;
        @(negedge clk_in);

        // Back-to-back CPU reads, request held through the ack
        b.cpu_req_in = 1; b.cpu_we_in = 0; b.cpu_addr_in = 19'h00031;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk_in);
            got = b.cpu_ack_o;
        end
        check("t6_first_ack", 32'(got), 1);
        check("t6_first_data", 32'(b.cpu_data_o), 32'(ref_mem[8'h31]));
        b.cpu_addr_in = 19'h00032;
        @(negedge clk_in);
        check("t6_turnaround_oe", {b.oe_o, b.cpu_ack_o}, 2'b10);
        lat = 0; got = 0; nol = 0;
        while (!got && lat < 40) begin
            @(negedge clk_in);
            lat++;
            if (!b.oe_o) nol++;
            if (lat == 1) check("t6_setup_oe", 32'(b.oe_o), 1);
            got = b.cpu_ack_o;
        end
        b.cpu_req_in = 0;
        check("t6_second_latency", lat, 3 + WS);
        check("t6_second_oe_cycles", nol, WS + 1);
        check("t6_second_data", 32'(b.cpu_data_o), 32'(ref_mem[8'h32]));
        @(negedge clk_in);

        // Zero wait states, DMA read, request dropped during SETUP
        ed = ref_mem[8'h55];
        b0.dma_req_in = 1; b0.dma_addr_in = 19'h00055;
        lat = 0; got = 0; nol = 0;
        while (!got && lat < 40) begin
            @(negedge clk_in);
            lat++;
            if (lat == 1) b0.dma_req_in = 0;
            if (!b0.oe_o) nol++;
            got = b0.dma_ack_o;
        end
        check("t5_latency", lat, 3);
        check("t5_oe_cycles", nol, 1);
        check("t5_dma_data", 32'(b0.dma_data_o), 32'(ed));
        check("t5_we_high", 32'(b0.we_o), 1);
        @(negedge clk_in);

        // Randomized mix of requesters, directions and early drops
        for (int r = 0; r < 40; r++) begin
            bit c, d;
            c = 1'($urandom_range(0, 1));
            d = 1'($urandom_range(0, 1));
            if (!c && !d) c = 1;
            run_txn(c, d, 1'($urandom_range(0, 1)), 19'($urandom), 16'($urandom),
                    19'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
